uart_tx_piso: RTL

UART_TX_PISO -- requirements
Module: uart_tx_piso

---
 rtl/uart_tx_piso.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_piso.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_piso
// Description : 8E1/8O1 UART transmitter. Accepts a byte on tx_start while
//               idle and shifts out start, 8 data bits (LSB first), parity
//               and stop, each held for CLKS_PER_BIT clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_piso #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                  c_BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE = c_BAUD_W'(1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ZERO = '0;
    localparam logic                c_PAR_INV  = (PARITY_ODD != 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_idx_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_parity;
    logic                w_parity_next;
    logic                r_tx_out;
    logic                w_tx_out_next;
    logic                r_tx_done;
    logic                w_tx_done_next;
    logic                w_baud_wrap;

    assign w_baud_wrap = (r_baud == c_BAUD_MAX);

    // Next-state, datapath and next-output decode. The serial line value is
    // derived from the *next* state so that the registered tx_out changes on
    // exactly the same edge as the state it belongs to.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_idx_next = r_bit_idx;
        w_tx_done_next = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (tx_start) begin
                    w_state_next  = c_START;
                    w_shift_next  = tx_data;
                    // Parity is frozen at acceptance because the shift
                    // register no longer holds the whole byte later on.
                    w_parity_next = (^tx_data) ^ c_PAR_INV;
                end
            end
            c_START: begin
                if (w_baud_wrap) begin
                    w_state_next = c_DATA;
                end
            end
            c_DATA: begin
                if (w_baud_wrap) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = c_PARITY;
                    end else begin
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            c_PARITY: begin
                if (w_baud_wrap) begin
                    w_state_next = c_STOP;
                end
            end
            c_STOP: begin
                if (w_baud_wrap) begin
                    w_state_next   = c_IDLE;
                    w_tx_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase

        // Bit index is only meaningful inside DATA; it restarts on entry.
        if (w_state_next != c_DATA || r_state != c_DATA) begin
            if (w_state_next != r_state) begin
                w_bit_idx_next = 3'd0;
            end
        end

        // Baud counter restarts on every state change and on wrap, and is
        // held at zero while idle.
        if (r_state == c_IDLE || w_state_next != r_state || w_baud_wrap) begin
            w_baud_next = c_BAUD_ZERO;
        end else begin
            w_baud_next = r_baud + c_BAUD_ONE;
        end

        case (w_state_next)
            c_START:  w_tx_out_next = 1'b0;
            c_DATA:   w_tx_out_next = w_shift_next[0];
            c_PARITY: w_tx_out_next = w_parity_next;
            default:  w_tx_out_next = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_baud    <= c_BAUD_ZERO;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
            r_tx_out  <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_tx_out  <= w_tx_out_next;
            r_tx_done <= w_tx_done_next;
        end
    end

    assign tx_out  = r_tx_out;
    assign tx_busy = (r_state != c_IDLE);
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire
